// File: rtl/mplc_bit_cpu_nest_if.sv
// ----------------------------------------------------------------------------
// mplc_bit_cpu_nest_if
//   Bundles every signal of the single-bit IL processor except clk/rst.
//   Groups: control (run, hold), program bus (i_a, i_d), data bus
//   (d_a, d_i, d_o, d_oe, d_we, d_rdy) and status (sp, err).
//   master : processor side (drives addresses, data out, strobes, status)
//   slave  : memory / core-controller side
// ----------------------------------------------------------------------------
interface mplc_bit_cpu_nest_if #(
    parameter int IA_W = 12,
    parameter int DA_W = 12,
    parameter int SP_W = 3
);
    logic                run;
    logic                hold;
    logic [IA_W-1:0]     i_a;
    logic [DA_W+5:0]     i_d;
    logic [DA_W-1:0]     d_a;
    logic                d_i;
    logic                d_o;
    logic                d_oe;
    logic                d_we;
    logic                d_rdy;
    logic [SP_W-1:0]     sp;
    logic                err;

    modport master (
        input  run, hold, i_d, d_i, d_rdy,
        output i_a, d_a, d_o, d_oe, d_we, sp, err
    );

    modport slave (
        output run, hold, i_d, d_i, d_rdy,
        input  i_a, d_a, d_o, d_oe, d_we, sp, err
    );
endinterface

// File: rtl/mplc_bit_cpu_nest.sv
// ----------------------------------------------------------------------------
// mplc_bit_cpu_nest
//   Three-stage (IF / DAT / EXE) single-bit instruction-list processor with a
//   LIFO parenthesis stack, S/R instructions and sticky stack-error flag.
//   Instruction word: {opc[3:0], mod[1:0], adr[DA_W-1:0]}.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset; release is re-synchronised over
//          two edges before the pipeline starts fetching
//   bus  : master modport of mplc_bit_cpu_nest_if (program bus, data bus,
//          run/hold control, sp/err status)
// ----------------------------------------------------------------------------
module mplc_bit_cpu_nest #(
    parameter int IA_W  = 12,
    parameter int DA_W  = 12,
    parameter int STK_D = 4,
    parameter int SP_W  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    mplc_bit_cpu_nest_if.master  bus
);
    localparam int IW = DA_W + 6;

    localparam logic [3:0] OP_LD    = 4'h1;
    localparam logic [3:0] OP_LDN   = 4'h2;
    localparam logic [3:0] OP_ST    = 4'h3;
    localparam logic [3:0] OP_STN   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_ANDN  = 4'h6;
    localparam logic [3:0] OP_OR    = 4'h7;
    localparam logic [3:0] OP_ORN   = 4'h8;
    localparam logic [3:0] OP_XOR   = 4'h9;
    localparam logic [3:0] OP_XORN  = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hB;
    localparam logic [3:0] OP_JMPC  = 4'hC;
    localparam logic [3:0] OP_JMPCN = 4'hD;
    localparam logic [3:0] OP_S     = 4'hE;

    localparam logic [1:0] MOD_NONE = 2'b00;
    localparam logic [1:0] MOD_PUSH = 2'b01;
    localparam logic [1:0] MOD_POP  = 2'b10;

    typedef struct packed {
        logic [3:0] opc;
        logic       cr;
    } stk_ent_t;

    function automatic logic is_logic(input logic [3:0] opc);
        return opc inside {OP_LD, OP_LDN, OP_AND, OP_ANDN, OP_OR, OP_ORN, OP_XOR, OP_XORN};
    endfunction

    function automatic logic is_inv(input logic [3:0] opc);
        return opc inside {OP_LDN, OP_ANDN, OP_ORN, OP_XORN};
    endfunction

    function automatic logic is_store(input logic [3:0] opc);
        return opc inside {OP_ST, OP_STN, OP_S, 4'hF};
    endfunction

    // acc is the accumulator side, val the operand (data bit or inner result)
    function automatic logic logic_op(input logic [3:0] opc, input logic acc, input logic val);
        logic r;
        case (opc)
            OP_LD:   r = val;
            OP_LDN:  r = ~val;
            OP_AND:  r = acc & val;
            OP_ANDN: r = acc & ~val;
            OP_OR:   r = acc | val;
            OP_ORN:  r = acc | ~val;
            OP_XOR:  r = acc ^ val;
            OP_XORN: r = acc ^ ~val;
            default: r = acc;
        endcase
        return r;
    endfunction

    // ---------------------------------------------------------------- state
    logic [1:0]      rst_sync_q, rst_sync_d;
    logic [IA_W-1:0] ip_q, ip_d;
    logic [IW-1:0]   ir_dat_q, ir_dat_d;
    logic [IW-1:0]   ir_exe_q, ir_exe_d;
    logic            din_q, din_d;
    logic            cr_q, cr_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic            err_q, err_d;
    stk_ent_t        stk_q [STK_D];
    stk_ent_t        stk_d [STK_D];

    // --------------------------------------------------------------- fields
    logic [3:0]      exe_opc, dat_opc;
    logic [1:0]      exe_mod, dat_mod;
    logic [DA_W-1:0] exe_adr, dat_adr;

    assign exe_opc = ir_exe_q[IW-1 -: 4];
    assign exe_mod = ir_exe_q[DA_W+1:DA_W];
    assign exe_adr = ir_exe_q[DA_W-1:0];
    assign dat_opc = ir_dat_q[IW-1 -: 4];
    assign dat_mod = ir_dat_q[DA_W+1:DA_W];
    assign dat_adr = ir_dat_q[DA_W-1:0];

    // Pipeline runs only once the released reset has passed both sync stages.
    logic active;
    assign active = bus.run & ~rst_sync_q[1];

    // ----------------------------------------------------------- EXE decode
    logic     exe_opok, exe_push, exe_pop, exe_wr_cr;
    logic     err_set, jump_taken, push_en;
    stk_ent_t pop_ent, push_ent;

    always_comb begin
        exe_opok  = (exe_mod == MOD_NONE) || (exe_mod == MOD_PUSH);
        exe_push  = (exe_mod == MOD_PUSH) && is_logic(exe_opc);
        exe_pop   = (exe_mod == MOD_POP);
        exe_wr_cr = (exe_opok && is_logic(exe_opc)) || exe_pop;
        err_set   = ~err_q && ((exe_push && (sp_q == SP_W'(STK_D))) ||
                               (exe_pop  && (sp_q == '0)));
        jump_taken = ~err_q && exe_opok &&
                     ((exe_opc == OP_JMP) ||
                      ((exe_opc == OP_JMPC)  &&  cr_q) ||
                      ((exe_opc == OP_JMPCN) && ~cr_q));
        pop_ent = '0;
        for (int i = 0; i < STK_D; i++) begin
            if (SP_W'(i + 1) == sp_q) pop_ent = stk_q[i];
        end
        push_ent = stk_ent_t'{opc: exe_opc, cr: cr_q};
    end

    // Each stack slot only changes when a push lands exactly on it.
    for (genvar gi = 0; gi < STK_D; gi++) begin : g_stk
        assign stk_d[gi] = (push_en && (sp_q == SP_W'(gi))) ? push_ent : stk_q[gi];
    end

    // ----------------------------------------------------------- DAT decode
    logic dat_opok, dat_rd, dat_st, hazard, st_en, kill, dat_stall;
    logic d_oe, d_we, d_o;

    always_comb begin
        dat_opok = (dat_mod == MOD_NONE) || (dat_mod == MOD_PUSH);
        dat_rd   = dat_opok && is_logic(dat_opc);
        dat_st   = dat_opok && is_store(dat_opc);
        // A store needs the CR the EXE instruction is still producing.
        hazard   = dat_st && exe_wr_cr;
        // S/R only write when CR=1; ST/STN always write.
        st_en    = (dat_opc == OP_ST) || (dat_opc == OP_STN) || cr_q;
        // Slot behind a taken jump or a stack error must not touch memory.
        kill     = jump_taken || err_set || err_q;
        d_oe     = dat_rd && ~kill;
        d_we     = dat_st && ~hazard && st_en && ~kill;
        dat_stall = hazard || ((d_oe || d_we) && ~bus.d_rdy);
        case (dat_opc)
            OP_ST:   d_o = cr_q;
            OP_STN:  d_o = ~cr_q;
            OP_S:    d_o = 1'b1;
            default: d_o = 1'b0;
        endcase
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b0};
        ip_d       = ip_q;
        ir_dat_d   = ir_dat_q;
        ir_exe_d   = '0;
        din_d      = bus.d_i;
        cr_d       = cr_q;
        sp_d       = sp_q;
        err_d      = err_q;
        push_en    = 1'b0;

        if (!active) begin
            ip_d     = '0;
            ir_dat_d = '0;
            cr_d     = 1'b0;
            sp_d     = '0;
            err_d    = 1'b0;
        end else if (err_q) begin
            // Frozen until run drops or rst: IP held, pipeline filled with NOPs.
            ir_dat_d = '0;
        end else begin
            // EXE: a faulting push/pop leaves CR and SP untouched.
            if (err_set) begin
                err_d = 1'b1;
            end else if (exe_push) begin
                push_en = 1'b1;
                sp_d    = sp_q + SP_W'(1);
                cr_d    = is_inv(exe_opc) ? ~din_q : din_q;
            end else if (exe_pop) begin
                sp_d = sp_q - SP_W'(1);
                cr_d = logic_op(pop_ent.opc, pop_ent.cr, cr_q);
            end else if ((exe_mod == MOD_NONE) && is_logic(exe_opc)) begin
                cr_d = logic_op(exe_opc, cr_q, din_q);
            end

            // IF/DAT advance
            if (err_set) begin
                ir_dat_d = '0;
            end else if (jump_taken) begin
                ip_d     = IA_W'(exe_adr);
                ir_dat_d = '0;
            end else if (dat_stall) begin
                ir_dat_d = ir_dat_q;
            end else begin
                ir_exe_d = ir_dat_q;
                if (bus.hold) begin
                    ir_dat_d = '0;
                end else begin
                    ir_dat_d = bus.i_d;
                    ip_d     = ip_q + IA_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync_q <= 2'b11;
            ip_q       <= '0;
            ir_dat_q   <= '0;
            ir_exe_q   <= '0;
            din_q      <= 1'b0;
            cr_q       <= 1'b0;
            sp_q       <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < STK_D; i++) stk_q[i] <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
            ip_q       <= ip_d;
            ir_dat_q   <= ir_dat_d;
            ir_exe_q   <= ir_exe_d;
            din_q      <= din_d;
            cr_q       <= cr_d;
            sp_q       <= sp_d;
            err_q      <= err_d;
            stk_q      <= stk_d;
        end
    end

    // --------------------------------------------------------------- outputs
    assign bus.i_a  = ip_q;
    assign bus.d_a  = dat_adr;
    assign bus.d_o  = d_o;
    assign bus.d_oe = d_oe;
    assign bus.d_we = d_we;
    assign bus.sp   = sp_q;
    assign bus.err  = err_q;
endmodule
